// File: rtl/dqn_pkg.sv
// -----------------------------------------------------------------------------
// dqn_pkg
// Shared definitions for the DQN SGD weight-update slice.
//   - Q7.8 signed fixed-point format constants
//   - parameter count and address-map base addresses
//   - FSM state encoding used by dqn_weight_update
// Address map (NUM_PARAMS = 74 entries):
//   0  .. 19 : w3[j][k]  at W3_BASE + j*5 + k   (j<4, k<5)
//   20 .. 23 : b3[j]     at B3_BASE + j
//   24 .. 68 : w2[i][k]  at W2_BASE + i*9 + k   (i<5, k<9)
//   69 .. 73 : b2[i]     at B2_BASE + i
// -----------------------------------------------------------------------------
package dqn_pkg;

   localparam int DATA_W         = 16;
   localparam int ADDR_W         = 7;
   localparam int DQN_FRAC_BITS  = 8;
   localparam int DQN_NUM_PARAMS = 74;
   localparam int PROD_W         = 2 * DATA_W;
   // Headroom for w - step: |step| < 2^23, so 25 bits never overflow.
   localparam int DIFF_W         = 25;

   localparam int W3_BASE = 0;
   localparam int B3_BASE = 20;
   localparam int W2_BASE = 24;
   localparam int B2_BASE = 69;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/dqn_sgd_mac.sv
// -----------------------------------------------------------------------------
// dqn_sgd_mac
// Two-stage SGD datapath: w_new = w - ((LR * delta) >>> FRAC_BITS).
//   Stage 1 registers the full-precision product and the target address.
//   Stage 2 looks up the current weight (via cur_addr/cur_weight), subtracts
//   the floor-shifted step in 25 bits and presents the write to the parent.
// Build option:
//   DQN_WU_SATURATE_EN defined   -> result clamped to [-32768, 32767]
//   DQN_WU_SATURATE_EN undefined -> low 16 bits kept (two's-complement wrap)
// Ports:
//   clk, rst      clock, asynchronous active-high reset (valid bit only)
//   beat_valid    accepted delta this cycle
//   beat_delta    signed Q7.8 gradient
//   beat_addr     parameter index of the gradient
//   cur_addr      stage-2 address for the parent's weight lookup
//   cur_weight    current weight at cur_addr (combinational from parent)
//   wr_en         stage-2 write strobe
//   wr_addr       stage-2 write address
//   wr_data       updated weight
// -----------------------------------------------------------------------------
module dqn_sgd_mac
   import dqn_pkg::*;
#(
   parameter int                        FRAC_BITS = DQN_FRAC_BITS,
   parameter logic signed [DATA_W-1:0]  LR        = 16'sh001A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat_valid,
   input  logic [DATA_W-1:0] beat_delta,
   input  logic [ADDR_W-1:0] beat_addr,
   output logic [ADDR_W-1:0] cur_addr,
   input  logic [DATA_W-1:0] cur_weight,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   logic signed [PROD_W-1:0] prod_p1;
   logic        [ADDR_W-1:0] addr_p1;
   logic                     vld_p1;
   logic signed [DIFF_W-1:0] diff_p2;

   // Arithmetic shift floors toward minus infinity, so a tiny negative
   // gradient still nudges the weight up by one LSB.
   function automatic logic signed [DIFF_W-1:0] sub_step(
      input logic signed [DATA_W-1:0] w,
      input logic signed [PROD_W-1:0] prod
   );
      return DIFF_W'(PROD_W'(w) - (prod >>> FRAC_BITS));
   endfunction

   function automatic logic [DATA_W-1:0] clamp16(
      input logic signed [DIFF_W-1:0] d
   );
`ifdef DQN_WU_SATURATE_EN
      if (d > 25'sd32767)
         return 16'h7FFF;
      else if (d < -25'sd32768)
         return 16'h8000;
      else
         return d[DATA_W-1:0];
`else
      return DATA_W'(d);
`endif
   endfunction

   // ---- stage 0 -> stage 1: product and address capture ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= beat_valid;
   end

   always_ff @(posedge clk) begin
      prod_p1 <= PROD_W'(LR) * PROD_W'(signed'(beat_delta));
      addr_p1 <= beat_addr;
   end

   // ---- stage 1 -> stage 2: shift, subtract, clamp, write back ----
   assign cur_addr = addr_p1;
   assign diff_p2  = sub_step(signed'(cur_weight), prod_p1);
   assign wr_en    = vld_p1;
   assign wr_addr  = addr_p1;
   assign wr_data  = clamp16(diff_p2);

endmodule

// File: rtl/dqn_weight_update.sv
// -----------------------------------------------------------------------------
// dqn_weight_update
// SGD weight-update stage downstream of the DQN backward pass. Holds all 74
// Q7.8 parameters (w3, b3, w2, b2), consumes one gradient per parameter in
// address order and applies w <= w - LR*delta through dqn_sgd_mac.
// Build option: DQN_WU_SATURATE_EN selects saturating (defined) or wrapping
// (undefined) result arithmetic inside dqn_sgd_mac.
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset; clears weights, aborts a pass
//   start        one-cycle pulse that begins a pass (honoured only when idle)
//   delta_valid  delta_in is valid this cycle
//   delta_in     signed gradient for the current parameter index
//   delta_ready  a delta is accepted this cycle when also valid
//   busy         pass in progress (RUN, DRAIN, DONE)
//   done         one-cycle pulse when the pass completes
//   rd_addr      read address; rd_data is combinational, 0 beyond the map
//   init_we      host write enable, honoured only when idle
//   init_addr    host write address; out-of-range writes are dropped
//   init_data    host write data
// -----------------------------------------------------------------------------
module dqn_weight_update
   import dqn_pkg::*;
#(
   parameter int                       FRAC_BITS  = DQN_FRAC_BITS,
   parameter logic signed [DATA_W-1:0] LR         = 16'sh001A,
   parameter int                       NUM_PARAMS = DQN_NUM_PARAMS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              delta_valid,
   input  logic [DATA_W-1:0] delta_in,
   output logic              delta_ready,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_PARAMS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_PARAMS);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   idx;
   logic                drain_cnt;
   logic                accept;
   logic                init_ok;

   logic [DATA_W-1:0]   w [NUM_PARAMS];

   logic [ADDR_W-1:0]   mac_cur_addr;
   logic                mac_wr_en;
   logic [ADDR_W-1:0]   mac_wr_addr;
   logic [DATA_W-1:0]   mac_wr_data;

   assign accept  = delta_valid && delta_ready;
   assign init_ok = init_we && (state == ST_IDLE) && (init_addr < ADDR_LIMIT);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RUN;
         ST_RUN:   if (accept && (idx == LAST_IDX)) state_nxt = ST_DRAIN;
         // Two DRAIN cycles cover the two-stage write latency, so the last
         // weight is already in storage when done is seen.
         ST_DRAIN: if (drain_cnt) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      delta_ready = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         ST_RUN: begin
            delta_ready = 1'b1;
            busy        = 1'b1;
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Parameter index of the next beat and the DRAIN cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         drain_cnt <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && start)
            idx <= '0;
         else if (accept)
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      end
   end

   dqn_sgd_mac #(
      .FRAC_BITS (FRAC_BITS),
      .LR        (LR)
   ) u_mac (
      .clk        (clk),
      .rst        (rst),
      .beat_valid (accept),
      .beat_delta (delta_in),
      .beat_addr  (idx),
      .cur_addr   (mac_cur_addr),
      .cur_weight (w[mac_cur_addr]),
      .wr_en      (mac_wr_en),
      .wr_addr    (mac_wr_addr),
      .wr_data    (mac_wr_data)
   );

   // Parameter storage. Host writes only occur in IDLE, when the pipeline
   // is empty, so the two write sources never collide in practice; the
   // datapath still takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PARAMS; i++)
            w[i] <= '0;
      end else if (mac_wr_en) begin
         w[mac_wr_addr] <= mac_wr_data;
      end else if (init_ok) begin
         w[init_addr] <= init_data;
      end
   end

   assign rd_data = (rd_addr < ADDR_LIMIT) ? w[rd_addr] : '0;

endmodule
